// File: rtl/length_rom_scheduler.sv
// Shares one lengths-ROM read port among CHANNEL_NUM length FIFOs: round-robin grants
// gated by per-channel words-left and FIFO credits, with write-enables delayed by ROM latency.
module length_rom_scheduler #(
  parameter int CHANNEL_NUM     = 8,
  parameter int CHANNEL_NUM_LOG = 3,
  parameter int ADDR_BITS       = 9,
  parameter int CNT_BITS        = 9,
  parameter int FIFO_DEPTH      = 16,
  parameter int ROM_LATENCY     = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [ADDR_BITS*CHANNEL_NUM-1:0] base_addr,
  input  logic [CNT_BITS*CHANNEL_NUM-1:0]  count,
  input  logic [CHANNEL_NUM-1:0]           fifo_read,
  output logic [ADDR_BITS-1:0]             rom_addr,
  output logic [CHANNEL_NUM-1:0]           fifo_wr_en,
  output logic [CHANNEL_NUM-1:0]           channel_done,
  output logic                             busy,
  output logic                             done
);
  localparam int CRED_BITS = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                     state_q;
  logic [ADDR_BITS-1:0]       addr_q      [CHANNEL_NUM];
  logic [CNT_BITS-1:0]        remaining_q [CHANNEL_NUM];
  logic [CRED_BITS-1:0]       credit_q    [CHANNEL_NUM];
  logic [CRED_BITS-1:0]       credit_d    [CHANNEL_NUM];
  logic [CHANNEL_NUM_LOG-1:0] rrPtr_q;
  logic [ROM_LATENCY-1:0]     pipeValid_q;
  logic [CHANNEL_NUM_LOG-1:0] pipeChan_q  [ROM_LATENCY];
  logic [ADDR_BITS-1:0]       romAddr_q;
  logic [CHANNEL_NUM-1:0]     wrEn_q;
  logic [CHANNEL_NUM-1:0]     chanDone_q;
  logic                       busy_q;
  logic                       done_q;

  logic [CHANNEL_NUM-1:0]     eligible;
  logic [CHANNEL_NUM-1:0]     creditInc;
  logic [CHANNEL_NUM-1:0]     creditDec;
  logic                       grantValid;
  logic [CHANNEL_NUM_LOG-1:0] grantIdx;
  logic [CHANNEL_NUM_LOG-1:0] cand;
  int                         idx;
  logic                       lastWord;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    eligible   = '0;
    grantValid = 1'b0;
    grantIdx   = '0;
    cand       = '0;
    idx        = 0;
    for (int i = 0; i < CHANNEL_NUM; i++)
      eligible[i] = (remaining_q[i] != '0) && (credit_q[i] != '0);
    if (state_q == RUN) begin
      for (int k = 1; k <= CHANNEL_NUM; k++) begin
        idx  = (int'(rrPtr_q) + k) % CHANNEL_NUM;
        cand = CHANNEL_NUM_LOG'(idx);
        if (!grantValid && eligible[cand]) begin
          grantValid = 1'b1;
          grantIdx   = cand;
        end
      end
    end
  end

  // A read returns one credit, a grant consumes one; reads on a full credit count are dropped.
  always_comb begin
    creditInc = '0;
    creditDec = '0;
    lastWord  = 1'b1;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      creditInc[i] = fifo_read[i] && (credit_q[i] != CRED_BITS'(FIFO_DEPTH));
      creditDec[i] = grantValid && (grantIdx == CHANNEL_NUM_LOG'(i));
      case ({creditInc[i], creditDec[i]})
        2'b10:   credit_d[i] = credit_q[i] + CRED_BITS'(1);
        2'b01:   credit_d[i] = credit_q[i] - CRED_BITS'(1);
        default: credit_d[i] = credit_q[i];
      endcase
      if ((remaining_q[i] != '0) && !(creditDec[i] && (remaining_q[i] == CNT_BITS'(1))))
        lastWord = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      romAddr_q   <= '0;
      wrEn_q      <= '0;
      chanDone_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pipeValid_q <= '0;
      rrPtr_q     <= CHANNEL_NUM_LOG'(CHANNEL_NUM - 1);
      for (int i = 0; i < CHANNEL_NUM; i++) begin
        credit_q[i]    <= CRED_BITS'(FIFO_DEPTH);
        addr_q[i]      <= '0;
        remaining_q[i] <= '0;
      end
      for (int k = 0; k < ROM_LATENCY; k++)
        pipeChan_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      for (int i = 0; i < CHANNEL_NUM; i++)
        credit_q[i] <= credit_d[i];

      // Stage 0 pairs with the address on rom_addr; the last stage fires the write-enable.
      pipeValid_q[0] <= grantValid;
      pipeChan_q[0]  <= grantIdx;
      for (int k = 1; k < ROM_LATENCY; k++) begin
        pipeValid_q[k] <= pipeValid_q[k-1];
        pipeChan_q[k]  <= pipeChan_q[k-1];
      end
      wrEn_q <= '0;
      if (pipeValid_q[ROM_LATENCY-1])
        wrEn_q[pipeChan_q[ROM_LATENCY-1]] <= 1'b1;

      case (state_q)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < CHANNEL_NUM; i++) begin
              addr_q[i]      <= base_addr[i*ADDR_BITS +: ADDR_BITS];
              remaining_q[i] <= count[i*CNT_BITS +: CNT_BITS];
              chanDone_q[i]  <= (count[i*CNT_BITS +: CNT_BITS] == '0);
            end
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (grantValid) begin
            romAddr_q             <= addr_q[grantIdx];
            addr_q[grantIdx]      <= addr_q[grantIdx] + ADDR_BITS'(1);
            remaining_q[grantIdx] <= remaining_q[grantIdx] - CNT_BITS'(1);
            rrPtr_q               <= grantIdx;
            if (remaining_q[grantIdx] == CNT_BITS'(1))
              chanDone_q[grantIdx] <= 1'b1;
          end
          if (lastWord)
            state_q <= DRAIN;
        end
        DRAIN: begin
          if (pipeValid_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr     = romAddr_q;
  assign fifo_wr_en   = wrEn_q;
  assign channel_done = chanDone_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_length_rom_scheduler.sv
// Bench for length_rom_scheduler: directed scenarios plus randomized matrices and consumer
// reads, compared every cycle against a cycle-level reference of the scheduling rules.
module tb_length_rom_scheduler;
  localparam int N     = 8;
  localparam int NLOG  = 3;
  localparam int AB    = 9;
  localparam int CB    = 9;
  localparam int DEPTH = 16;
  localparam int LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [AB*N-1:0]   base_addr;
  logic [CB*N-1:0]   count;
  logic [N-1:0]      fifo_read;
  logic [AB-1:0]     rom_addr;
  logic [N-1:0]      fifo_wr_en;
  logic [N-1:0]      channel_done;
  logic              busy;
  logic              done;

  length_rom_scheduler #(
    .CHANNEL_NUM(N), .CHANNEL_NUM_LOG(NLOG), .ADDR_BITS(AB), .CNT_BITS(CB),
    .FIFO_DEPTH(DEPTH), .ROM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .fifo_read(fifo_read), .rom_addr(rom_addr), .fifo_wr_en(fifo_wr_en),
    .channel_done(channel_done), .busy(busy), .done(done)
  );

  typedef enum {M_IDLE, M_RUN, M_DRAIN} phase_t;

  phase_t       phase;
  int           addrM [N];
  int           remM  [N];
  int           credM [N];
  int           occM  [N];
  int           rr;
  int           cyc;
  int           pending;
  logic [N-1:0] wrAt [64];
  logic [AB-1:0] expRom;
  logic [N-1:0] expWr;
  logic [N-1:0] expCdone;
  logic         expBusy;
  logic         expDone;
  int           total = 0;
  int           bad = 0;
  int           wrSeen;
  int           wrLog[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference: advances the scheduling rules across one clock edge.
  task automatic modelEdge(input logic r, input logic s, input logic [N-1:0] rd,
                           input logic [AB*N-1:0] ba, input logic [CB*N-1:0] cn);
    int n;
    int g;
    int c;
    int inc;
    int dec;
    bit allZero;
    n = cyc + 1;
    if (r) begin
      phase = M_IDLE; expRom = '0; expCdone = '0; expBusy = 1'b0; expDone = 1'b0;
      rr = N - 1; pending = 0;
      for (int i = 0; i < N; i++) begin
        credM[i] = DEPTH; occM[i] = 0; addrM[i] = 0; remM[i] = 0;
      end
      for (int k = 0; k < 64; k++) wrAt[k] = '0;
    end else begin
      for (int i = 0; i < N; i++)
        if (wrAt[cyc % 64][i]) begin occM[i]++; pending--; end
      wrAt[cyc % 64] = '0;
      for (int i = 0; i < N; i++)
        if (rd[i]) occM[i]--;
      expDone = 1'b0;
      g = -1;
      case (phase)
        M_IDLE: if (s) begin
          for (int i = 0; i < N; i++) begin
            addrM[i] = int'(ba[i*AB +: AB]);
            remM[i] = int'(cn[i*CB +: CB]);
            expCdone[i] = (remM[i] == 0);
          end
          phase = M_RUN; expBusy = 1'b1;
        end
        M_RUN: begin
          for (int k = 1; k <= N; k++) begin
            c = (rr + k) % N;
            if (g < 0 && remM[c] > 0 && credM[c] > 0) g = c;
          end
          if (g >= 0) begin
            expRom = AB'(addrM[g]);
            addrM[g] = (addrM[g] + 1) % (1 << AB);
            remM[g]--;
            rr = g;
            if (remM[g] == 0) expCdone[g] = 1'b1;
            wrAt[(n + LAT) % 64][g] = 1'b1;
            pending++;
          end
          allZero = 1;
          for (int i = 0; i < N; i++) if (remM[i] != 0) allZero = 0;
          if (allZero) phase = M_DRAIN;
        end
        default: if (pending == 0) begin
          expDone = 1'b1; expBusy = 1'b0; phase = M_IDLE;
        end
      endcase
      for (int i = 0; i < N; i++) begin
        inc = (rd[i] && credM[i] < DEPTH) ? 1 : 0;
        dec = (g == i) ? 1 : 0;
        credM[i] = credM[i] + inc - dec;
      end
    end
    expWr = wrAt[n % 64];
    cyc = n;
  endtask

  task automatic checkAll();
    checkOutput("rom_addr", 32'(rom_addr), 32'(expRom));
    checkOutput("fifo_wr_en", 32'(fifo_wr_en), 32'(expWr));
    checkOutput("channel_done", 32'(channel_done), 32'(expCdone));
    checkOutput("busy", 32'(busy), 32'(expBusy));
    checkOutput("done", 32'(done), 32'(expDone));
    for (int i = 0; i < N; i++)
      if (fifo_wr_en[i]) begin wrSeen++; wrLog.push_back(i); end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic [N-1:0] rd,
                               input logic [AB*N-1:0] ba, input logic [CB*N-1:0] cn);
    rst = r; start = s; fifo_read = rd; base_addr = ba; count = cn;
    modelEdge(r, s, rd, ba, cn);
    @(posedge clk);
    #1;
    checkAll();
  endtask

  // Consumer reads only from FIFOs that already hold data.
  function automatic logic [N-1:0] randomRead(input int prob);
    logic [N-1:0] rd;
    rd = '0;
    for (int i = 0; i < N; i++)
      if (occM[i] > 0 && $urandom_range(99) < prob) rd[i] = 1'b1;
    return rd;
  endfunction

  task automatic randomConfig(output logic [AB*N-1:0] ba, output logic [CB*N-1:0] cn,
                              input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      ba[i*AB +: AB] = AB'($urandom_range((1 << AB) - 1));
      cn[i*CB +: CB] = CB'($urandom_range(hi, lo));
    end
  endtask

  task automatic runUntilIdle(input int bound, input int prob, input int midStartAt);
    logic [AB*N-1:0] altBa;
    logic [CB*N-1:0] altCn;
    int k;
    k = 0;
    while (phase != M_IDLE && k < bound) begin
      if (k == midStartAt) begin
        randomConfig(altBa, altCn, 1, 30);
        applyStimulus(1'b0, 1'b1, randomRead(prob), altBa, altCn);
      end else begin
        applyStimulus(1'b0, 1'b0, randomRead(prob), base_addr, count);
      end
      k++;
    end
    if (phase != M_IDLE) checkOutput("run_timeout", 32'(k), 32'(bound + 1));
    repeat (2) applyStimulus(1'b0, 1'b0, randomRead(prob), base_addr, count);
  endtask

  initial begin
    logic [AB*N-1:0] ba;
    logic [CB*N-1:0] cn;
    rst = 1'b1; start = 1'b0; fifo_read = '0; base_addr = '0; count = '0;
    cyc = 0; wrSeen = 0;
    repeat (2) applyStimulus(1'b1, 1'b0, '0, '0, '0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);

    // Basic fetch: two words per channel, bases at multiples of 64.
    for (int i = 0; i < N; i++) begin
      ba[i*AB +: AB] = AB'(i * 64);
      cn[i*CB +: CB] = CB'(2);
    end
    wrSeen = 0;
    applyStimulus(1'b0, 1'b1, '0, ba, cn);
    runUntilIdle(100, 0, -1);
    checkOutput("basic_writes", 32'(wrSeen), 32'd16);

    // Credit stall on a single channel of 20 words.
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    randomConfig(ba, cn, 0, 0);
    cn[0 +: CB] = CB'(20);
    wrSeen = 0;
    applyStimulus(1'b0, 1'b1, '0, ba, cn);
    repeat (30) applyStimulus(1'b0, 1'b0, '0, ba, cn);
    checkOutput("stall_16", 32'(wrSeen), 32'd16);
    repeat (4) applyStimulus(1'b0, 1'b0, 8'h01, ba, cn);
    repeat (10) applyStimulus(1'b0, 1'b0, '0, ba, cn);
    checkOutput("stall_20", 32'(wrSeen), 32'd20);
    runUntilIdle(200, 60, -1);

    // Zero counts are skipped and marked done straight away.
    applyStimulus(1'b1, 1'b0, '0, '0, '0);
    randomConfig(ba, cn, 0, 0);
    cn[1*CB +: CB] = CB'(3);
    cn[3*CB +: CB] = CB'(1);
    wrLog.delete();
    applyStimulus(1'b0, 1'b1, '0, ba, cn);
    checkOutput("skip_cdone", 32'(channel_done), 32'h0000_00F5);
    runUntilIdle(50, 0, -1);
    checkOutput("skip_nwr", 32'(wrLog.size()), 32'd4);
    checkOutput("skip_wr0", 32'(wrLog[0]), 32'd1);
    checkOutput("skip_wr1", 32'(wrLog[1]), 32'd3);
    checkOutput("skip_wr2", 32'(wrLog[2]), 32'd1);
    checkOutput("skip_wr3", 32'(wrLog[3]), 32'd1);

    // Random matrices with credits carried over; one takes a start pulse while busy.
    for (int m = 0; m < 8; m++) begin
      randomConfig(ba, cn, (m == 2) ? 5 : 0, 24);
      applyStimulus(1'b0, 1'b1, randomRead(50), ba, cn);
      runUntilIdle(3000, int'($urandom_range(90, 20)), (m == 2) ? 4 : -1);
    end

    // Reset in the middle of a run, then a clean matrix.
    randomConfig(ba, cn, 10, 24);
    applyStimulus(1'b0, 1'b1, '0, ba, cn);
    repeat (8) applyStimulus(1'b0, 1'b0, randomRead(50), ba, cn);
    applyStimulus(1'b1, 1'b0, '0, ba, cn);
    repeat (3) applyStimulus(1'b0, 1'b0, '0, ba, cn);
    randomConfig(ba, cn, 0, 20);
    applyStimulus(1'b0, 1'b1, '0, ba, cn);
    runUntilIdle(3000, 40, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
